// File: rtl/multicycle_control_pkg.sv
// Shared types, opcode/funct codes and opcode decode for the multicycle control sequencer.
// MC_IMMLOGIC_EN: also accept andi/ori/slti/sltiu as immediate ALU instructions.
package multicycle_control_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned AOP_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_type;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_NOR  = 3'd4,
        ALU_SLT  = 3'd5,
        ALU_SLTU = 3'd6
    } alu_oper_type;

    typedef enum logic [AOP_W-1:0] {
        AOP_ADD   = 2'd0,
        AOP_SUB   = 2'd1,
        AOP_FUNCT = 2'd2,
        AOP_IMM   = 2'd3
    } aluop_type;

    // opcode_type codes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // funct_type codes
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'b100111;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_SLTU = 6'b101011;

    // Successor of S_DECODE; S_FETCH means the opcode is not recognised.
    function automatic state_type decode_next(input logic [OP_W-1:0] op);
        state_type nxt;
        unique case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXEC;
            OP_BEQ:       nxt = S_BRANCH;
            OP_ADDI:      nxt = S_IMMEX;
            OP_J:         nxt = S_JUMP;
`ifdef MC_IMMLOGIC_EN
            OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU: nxt = S_IMMEX;
`endif
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath/ALU (slave).
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic [FUNCT_W-1:0] funct;
    logic               alu_zero;
    logic               mem_ready;
    alu_oper_type       alu_sel;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               illegal;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output alu_sel, alu_src_a, alu_src_b, pc_write, pc_src, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, illegal, state_o
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  alu_sel, alu_src_a, alu_src_b, pc_write, pc_src, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, illegal, state_o
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the sequencer's ALU operation class plus funct/opcode onto the ALU operation.
// The immediate mapping is always present; unreachable opcodes are filtered at decode.
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  aluop_type          aluop,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [OP_W-1:0]    opcode,
    output alu_oper_type       alu_oper,
    output logic               illegal_funct
);

    // Depends on funct only, so the FSM may read it while choosing aluop.
    always_comb begin
        illegal_funct = 1'b0;
        unique case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: illegal_funct = 1'b0;
            default: illegal_funct = 1'b1;
        endcase
    end

    always_comb begin
        alu_oper = ALU_ADD;
        unique case (aluop)
            AOP_ADD: alu_oper = ALU_ADD;
            AOP_SUB: alu_oper = ALU_SUB;
            AOP_FUNCT: begin
                unique case (funct)
                    FN_SUB:  alu_oper = ALU_SUB;
                    FN_AND:  alu_oper = ALU_AND;
                    FN_OR:   alu_oper = ALU_OR;
                    FN_NOR:  alu_oper = ALU_NOR;
                    FN_SLT:  alu_oper = ALU_SLT;
                    FN_SLTU: alu_oper = ALU_SLTU;
                    default: alu_oper = ALU_ADD;
                endcase
            end
            AOP_IMM: begin
                unique case (opcode)
                    OP_ANDI:  alu_oper = ALU_AND;
                    OP_ORI:   alu_oper = ALU_OR;
                    OP_SLTI:  alu_oper = ALU_SLT;
                    OP_SLTIU: alu_oper = ALU_SLTU;
                    default:  alu_oper = ALU_ADD;
                endcase
            end
            default: alu_oper = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control sequencer: drives ALU selects, PC/IR/register-file and memory strobes.
// Build option MC_IMMLOGIC_EN (see package) adds andi/ori/slti/sltiu decode.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit RESET_TO_IDLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    localparam state_type RESET_STATE = RESET_TO_IDLE ? S_IDLE : S_FETCH;

    state_type       state_q, next_state;
    logic [OP_W-1:0] op_q;
    logic            illegal_q;
    logic            set_illegal, op_load;
    aluop_type       aluop;
    alu_oper_type    alu_oper;
    logic            illegal_funct;
    logic            alu_src_a, pc_write, iord, mem_read, mem_write;
    logic            ir_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0]      alu_src_b, pc_src;

    multicycle_control_alu_decoder u_alu_decoder (
        .aluop         (aluop),
        .funct         (bus.funct),
        .opcode        (op_q),
        .alu_oper      (alu_oper),
        .illegal_funct (illegal_funct)
    );

    // Next state and strobes; everything is forced to its idle value while in reset.
    always_comb begin
        next_state  = state_q;
        aluop       = AOP_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        set_illegal = 1'b0;
        op_load     = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                S_IDLE: next_state = S_FETCH;
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    if (bus.mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b   = 2'd3;
                    op_load     = 1'b1;
                    next_state  = decode_next(bus.opcode);
                    set_illegal = (next_state == S_FETCH);
                end
                S_MEMADR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'd2;
                    next_state = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (bus.mem_ready) next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (bus.mem_ready) next_state = S_FETCH;
                end
                S_EXEC: begin
                    alu_src_a   = 1'b1;
                    aluop       = illegal_funct ? AOP_ADD : AOP_FUNCT;
                    set_illegal = illegal_funct;
                    next_state  = illegal_funct ? S_FETCH : S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    next_state = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    aluop      = AOP_SUB;
                    pc_src     = 2'd1;
                    pc_write   = bus.alu_zero;
                    next_state = S_FETCH;
                end
                S_IMMEX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'd2;
                    aluop      = AOP_IMM;
                    next_state = S_IMMWB;
                end
                S_IMMWB: begin
                    reg_write  = 1'b1;
                    next_state = S_FETCH;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'd2;
                    next_state = S_FETCH;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

    // State, latched opcode (needed after decode) and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (op_load)     op_q      <= bus.opcode;
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    assign bus.alu_sel    = alu_oper;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.illegal    = illegal_q;
    assign bus.state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction cycle-by-cycle expectation lists
// built from the instruction-level behaviour, with randomized waits and don't-care inputs.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_sel;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctl_t;

    typedef struct packed {
        logic [1:0] rdy;       // 0: drive 0, 1: drive 1, 2: random
        logic       pin_op;    // drive the instruction's opcode this cycle
        logic       pin_fn;    // drive the instruction's funct this cycle
        logic       br;        // pc_write follows alu_zero
        logic       ill_after; // illegal becomes 1 from the next cycle on
        ctl_t       exp;
    } step_t;

    localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_R = 3, K_BEQ = 4, K_IMM = 5, K_J = 6;
    localparam logic [1:0] RDY0 = 2'd0, RDY1 = 2'd1, RDYX = 2'd2;

    logic clk;
    logic rst_n;
    multicycle_control_if bus ();

    multicycle_control #(.RESET_TO_IDLE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    step_t       q[$];
    logic [5:0]  cur_op, cur_fn;
    logic        ill_model;
    int          ir_count;
    int          zero_mode; // 0/1 fixed alu_zero, 2 random

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t obs_ctl();
        ctl_t c;
        c.mem_read   = bus.mem_read;
        c.mem_write  = bus.mem_write;
        c.ir_write   = bus.ir_write;
        c.pc_write   = bus.pc_write;
        c.pc_src     = bus.pc_src;
        c.iord       = bus.iord;
        c.alu_src_a  = bus.alu_src_a;
        c.alu_src_b  = bus.alu_src_b;
        c.alu_sel    = bus.alu_sel;
        c.reg_write  = bus.reg_write;
        c.reg_dst    = bus.reg_dst;
        c.mem_to_reg = bus.mem_to_reg;
        return c;
    endfunction

    function automatic int op_kind(input logic [5:0] op);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
            6'b001000: return K_IMM;
            6'b000010: return K_J;
`ifdef MC_IMMLOGIC_EN
            6'b001100, 6'b001101, 6'b001010, 6'b001011: return K_IMM;
`endif
            default:   return K_ILL;
        endcase
    endfunction

    // {known, alu operation} for an R-type funct
    function automatic logic [3:0] fn_map(input logic [5:0] fn);
        case (fn)
            6'b100000: return {1'b1, ALU_ADD};
            6'b100010: return {1'b1, ALU_SUB};
            6'b100100: return {1'b1, ALU_AND};
            6'b100101: return {1'b1, ALU_OR};
            6'b100111: return {1'b1, ALU_NOR};
            6'b101010: return {1'b1, ALU_SLT};
            6'b101011: return {1'b1, ALU_SLTU};
            default:   return {1'b0, ALU_ADD};
        endcase
    endfunction

    function automatic logic [2:0] imm_map(input logic [5:0] op);
        case (op)
            6'b001100: return ALU_AND;
            6'b001101: return ALU_OR;
            6'b001010: return ALU_SLT;
            6'b001011: return ALU_SLTU;
            default:   return ALU_ADD;
        endcase
    endfunction

    task automatic push(input logic [1:0] rdy, input logic pin_op, input logic pin_fn,
                        input logic br, input logic ill, input ctl_t c);
        step_t s;
        s.rdy = rdy; s.pin_op = pin_op; s.pin_fn = pin_fn; s.br = br; s.ill_after = ill; s.exp = c;
        q.push_back(s);
    endtask

    // Expected cycle list of one instruction starting in fetch.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        ctl_t c;
        int k;
        logic [3:0] m;
        q.delete();
        k = op_kind(op);
        for (int i = 0; i < fw; i++) begin
            c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'd1; c.alu_sel = ALU_ADD;
            push(RDY0, 1'b0, 1'b0, 1'b0, 1'b0, c);
        end
        c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'd1; c.ir_write = 1'b1; c.pc_write = 1'b1;
        c.alu_sel = ALU_ADD;
        push(RDY1, 1'b0, 1'b0, 1'b0, 1'b0, c);
        c = '0; c.alu_src_b = 2'd3; c.alu_sel = ALU_ADD;
        push(RDYX, 1'b1, 1'b0, 1'b0, k == K_ILL, c);
        case (k)
            K_LW, K_SW: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_sel = ALU_ADD;
                push(RDYX, 1'b0, 1'b0, 1'b0, 1'b0, c);
                for (int i = 0; i <= mw; i++) begin
                    c = '0; c.iord = 1'b1; c.alu_sel = ALU_ADD;
                    if (k == K_LW) c.mem_read = 1'b1; else c.mem_write = 1'b1;
                    push((i == mw) ? RDY1 : RDY0, 1'b0, 1'b0, 1'b0, 1'b0, c);
                end
                if (k == K_LW) begin
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.alu_sel = ALU_ADD;
                    push(RDYX, 1'b0, 1'b0, 1'b0, 1'b0, c);
                end
            end
            K_R: begin
                m = fn_map(fn);
                c = '0; c.alu_src_a = 1'b1; c.alu_sel = m[2:0];
                push(RDYX, 1'b0, 1'b1, 1'b0, !m[3], c);
                if (m[3]) begin
                    c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_sel = ALU_ADD;
                    push(RDYX, 1'b0, 1'b0, 1'b0, 1'b0, c);
                end
            end
            K_BEQ: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_sel = ALU_SUB; c.pc_src = 2'd1;
                push(RDYX, 1'b0, 1'b0, 1'b1, 1'b0, c);
            end
            K_IMM: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_sel = imm_map(op);
                push(RDYX, 1'b0, 1'b0, 1'b0, 1'b0, c);
                c = '0; c.reg_write = 1'b1; c.alu_sel = ALU_ADD;
                push(RDYX, 1'b0, 1'b0, 1'b0, 1'b0, c);
            end
            K_J: begin
                c = '0; c.pc_write = 1'b1; c.pc_src = 2'd2; c.alu_sel = ALU_ADD;
                push(RDYX, 1'b0, 1'b0, 1'b0, 1'b0, c);
            end
            default: ;
        endcase
    endtask

    // Called at posedge+1; runs up to 'limit' cycles of the expectation list.
    task automatic run_steps(input string name, input int limit);
        step_t s;
        ctl_t  e;
        int    n;
        n = (limit < q.size()) ? limit : q.size();
        for (int i = 0; i < n; i++) begin
            s = q[i];
            bus.opcode = s.pin_op ? cur_op : 6'($urandom);
            bus.funct  = s.pin_fn ? cur_fn : 6'($urandom);
            case (s.rdy)
                RDY0:    bus.mem_ready = 1'b0;
                RDY1:    bus.mem_ready = 1'b1;
                default: bus.mem_ready = 1'($urandom);
            endcase
            bus.alu_zero = (zero_mode == 2) ? 1'($urandom) : (zero_mode == 1);
            #2;
            e = s.exp;
            if (s.br) e.pc_write = bus.alu_zero;
            check($sformatf("%s_c%0d_ctl", name, i), 32'(obs_ctl()), 32'(e));
            check($sformatf("%s_c%0d_illegal", name, i), 32'(bus.illegal), 32'(ill_model));
            check($sformatf("%s_c%0d_rd_wr_excl", name, i), 32'(bus.mem_read & bus.mem_write), 32'(0));
            check($sformatf("%s_c%0d_pc_reg_excl", name, i), 32'(bus.pc_write & bus.reg_write), 32'(0));
            if (bus.ir_write) ir_count++;
            if (s.ill_after) ill_model = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input int limit);
        cur_op = op;
        cur_fn = fn;
        check({name, "_starts_in_fetch"}, 32'(bus.state_o), 32'(S_FETCH));
        build(op, fn, fw, mw);
        ir_count = 0;
        run_steps(name, limit);
    endtask

    task automatic check_reset_idle(input string name);
        ctl_t z;
        z = '0; z.alu_sel = ALU_ADD;
        check({name, "_ctl"}, 32'(obs_ctl()), 32'(z));
        check({name, "_state"}, 32'(bus.state_o), 32'(S_IDLE));
        check({name, "_illegal"}, 32'(bus.illegal), 32'(0));
    endtask

    logic [5:0] op_list [12];
    logic [5:0] fn_list [9];

    initial begin
        op_list = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010,
                    6'b001100, 6'b001101, 6'b001010, 6'b001011, 6'b111111, 6'b000001};
        fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                    6'b101010, 6'b101011, 6'b000000, 6'b111111};
        rst_n         = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b1;
        ill_model     = 1'b0;
        zero_mode     = 2;
        ir_count      = 0;

        // Reset: strobes idle, S_IDLE, illegal clear
        repeat (2) @(posedge clk);
        #1;
        check_reset_idle("reset");
        rst_n = 1'b1;
        #2;
        check_reset_idle("idle_after_reset");
        @(posedge clk); #1;

        // R add with memory always ready: 4 cycles
        run_instr("r_add", 6'b000000, 6'b100000, 0, 0, 1000);

        // lw: 2 fetch waits + 3 read waits -> 10 cycles, one IR load
        run_instr("lw_waits", 6'b100011, 6'b000000, 2, 3, 1000);
        check("lw_ir_write_pulses", 32'(ir_count), 32'(1));

        // beq taken and not taken
        zero_mode = 1;
        run_instr("beq_taken", 6'b000100, 6'b000000, 0, 0, 1000);
        zero_mode = 0;
        run_instr("beq_not_taken", 6'b000100, 6'b000000, 1, 0, 1000);
        zero_mode = 2;

        // ori: OR immediate when enabled, illegal otherwise
        run_instr("ori", 6'b001101, 6'b000000, 0, 0, 1000);
        run_instr("sw", 6'b101011, 6'b000000, 0, 2, 1000);
        run_instr("j", 6'b000010, 6'b000000, 0, 0, 1000);

        // Unknown funct: illegal, no writeback, next fetch normal
        run_instr("r_bad_funct", 6'b000000, 6'b000000, 0, 0, 1000);
        run_instr("addi_after_bad", 6'b001000, 6'b000000, 1, 0, 1000);
        run_instr("r_sub", 6'b000000, 6'b100010, 0, 0, 1000);

        // Randomized instruction stream
        for (int t = 0; t < 60; t++) begin
            run_instr($sformatf("rnd%0d", t),
                      op_list[$urandom_range(0, 11)], fn_list[$urandom_range(0, 8)],
                      $urandom_range(0, 2), $urandom_range(0, 2), 1000);
        end

        // Reset while lw waits in the read state: request dropped, restart via S_IDLE
        run_instr("lw_reset", 6'b100011, 6'b000000, 0, 5, 4);
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        ill_model = 1'b0;
        #2;
        check_reset_idle("reset_mid_memrd");
        @(posedge clk); #1;
        check_reset_idle("reset_held");
        rst_n = 1'b1;
        #2;
        check_reset_idle("idle_after_reset2");
        @(posedge clk); #1;
        run_instr("fetch_after_reset", 6'b001000, 6'b000000, 1, 0, 1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
